// File: rtl/lfsr_rng.sv
// Galois LFSR random source with reseeding, zero-state protection and a
// rejection-sampling request/valid port returning values in [0, limit-1].
module lfsr_rng #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
    parameter int              OUT_W   = 4,
    parameter int              MAX_TRY = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             ready,
    output logic             valid,
    output logic [OUT_W-1:0] rnd,
    output logic             fb,
    output logic [WIDTH-1:0] state_o
);

    localparam int TRY_W = $clog2(MAX_TRY + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY);

    typedef enum logic {IDLE, DRAW} fsm_t;

    fsm_t             r_fsm;
    logic [WIDTH-1:0] r_lfsr;
    logic [OUT_W-1:0] r_lim;
    logic [TRY_W-1:0] r_try;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_step_safe;
    logic [WIDTH-1:0] w_seed;
    logic [OUT_W-1:0] w_cand;
    logic [TRY_W-1:0] w_try_inc;
    logic             w_accept;

    assign w_step      = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    // A maximal-length mask never reaches zero from a non-zero state; the
    // guard only matters if the mask is wrong, and keeps the generator alive.
    assign w_step_safe = (w_step == '0) ? SEED : w_step;
    assign w_seed      = (seed_in == '0) ? SEED : seed_in;
    assign w_cand      = r_lfsr[OUT_W-1:0];
    assign w_try_inc   = r_try + TRY_W'(1);
    assign w_accept    = (r_lim == '0) || (w_cand < r_lim);

    assign ready   = (r_fsm == IDLE);
    assign state_o = r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
            r_fsm  <= IDLE;
            r_lim  <= '0;
            r_try  <= '0;
            rnd    <= '0;
            fb     <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (seed_load)
                r_lfsr <= w_seed;
            else if (r_fsm == DRAW || en)
                r_lfsr <= w_step_safe;

            case (r_fsm)
                IDLE: begin
                    if (req) begin
                        r_lim <= limit;
                        r_try <= '0;
                        r_fsm <= DRAW;
                    end
                end
                DRAW: begin
                    // Candidate is taken from the pre-update state, so a
                    // concurrent seed_load only affects the next draw.
                    if (w_accept) begin
                        rnd   <= w_cand;
                        fb    <= 1'b0;
                        valid <= 1'b1;
                        r_fsm <= IDLE;
                    end else if (w_try_inc == TRY_LAST) begin
                        rnd   <= '0;
                        fb    <= 1'b1;
                        valid <= 1'b1;
                        r_fsm <= IDLE;
                    end else begin
                        r_try <= w_try_inc;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: default instance plus a MAX_TRY=2 instance
// for the fallback path; both share all inputs.
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        req = 1'b0;
    logic [3:0]  limit = '0;

    logic        ready, valid, fb;
    logic [3:0]  rnd;
    logic [15:0] state_o;
    logic        ready2, valid2, fb2;
    logic [3:0]  rnd2;
    logic [15:0] state2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lfsr_rng dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .limit(limit), .ready(ready),
        .valid(valid), .rnd(rnd), .fb(fb), .state_o(state_o)
    );

    lfsr_rng #(.MAX_TRY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .limit(limit), .ready(ready2),
        .valid(valid2), .rnd(rnd2), .fb(fb2), .state_o(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = '0;
        req = 1'b0; limit = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (state_o !== 16'hACE1) begin nerr++; $display("FAIL reset_state got %h exp ACE1", state_o); end
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", ready); end
        nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", valid); end
        nvec++; if (rnd !== 4'd0 || fb !== 1'b0) begin nerr++; $display("FAIL reset_rnd_fb got %h/%b exp 0/0", rnd, fb); end
    endtask

    task automatic test_free_run();
        logic [15:0] exp_seq [7] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C,
                                     16'h1C4E, 16'h0E27, 16'hB313};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            nvec++;
            if (state_o !== exp_seq[i]) begin
                nerr++; $display("FAIL free_run[%0d] got %h exp %h", i, state_o, exp_seq[i]);
            end
            tick();
        end
        en = 1'b0;
    endtask

    task automatic test_full_period();
        int zero_seen = 0;
        int early = 0;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (state_o == 16'h0000) zero_seen++;
            if (i < 65535 && state_o == 16'hACE1) early++;
        end
        en = 1'b0;
        nvec++; if (zero_seen != 0) begin nerr++; $display("FAIL period_zero got %0d zero states exp 0", zero_seen); end
        nvec++; if (early != 0) begin nerr++; $display("FAIL period_early got %0d early returns exp 0", early); end
        nvec++; if (state_o !== 16'hACE1) begin nerr++; $display("FAIL period_end got %h exp ACE1", state_o); end
    endtask

    task automatic test_ranged();
        do_reset();
        req = 1'b1; limit = 4'd0;
        tick();                         // acceptance edge
        req = 1'b0;
        nvec++; if (ready !== 1'b0 || valid !== 1'b0) begin nerr++; $display("FAIL ranged_busy got rdy=%b vld=%b exp 0/0", ready, valid); end
        tick();
        nvec++; if (valid !== 1'b1 || rnd !== 4'd1 || fb !== 1'b0) begin nerr++; $display("FAIL ranged_first got vld=%b rnd=%h fb=%b exp 1/1/0", valid, rnd, fb); end
        nvec++; if (ready !== 1'b1 || state_o !== 16'hE270) begin nerr++; $display("FAIL ranged_ready got rdy=%b st=%h exp 1/E270", ready, state_o); end
        req = 1'b1; limit = 4'd5;       // back-to-back, in the valid cycle
        tick();
        req = 1'b0;
        nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL ranged_pulse got %b exp 0", valid); end
        tick();
        nvec++; if (valid !== 1'b1 || rnd !== 4'd0 || fb !== 1'b0) begin nerr++; $display("FAIL ranged_second got vld=%b rnd=%h fb=%b exp 1/0/0", valid, rnd, fb); end
        tick();
        nvec++; if (valid !== 1'b0 || rnd !== 4'd0 || state_o !== 16'h7138) begin nerr++; $display("FAIL ranged_hold got vld=%b rnd=%h st=%h exp 0/0/7138", valid, rnd, state_o); end
    endtask

    task automatic test_reject();
        do_reset();
        req = 1'b1; limit = 4'd1;
        tick();
        req = 1'b0; limit = 4'd0;       // must not affect the captured bound
        tick();
        nvec++; if (valid !== 1'b0 || ready !== 1'b0) begin nerr++; $display("FAIL reject_first got vld=%b rdy=%b exp 0/0", valid, ready); end
        tick();
        nvec++; if (valid !== 1'b1 || rnd !== 4'd0 || fb !== 1'b0) begin nerr++; $display("FAIL reject_accept got vld=%b rnd=%h fb=%b exp 1/0/0", valid, rnd, fb); end
        nvec++; if (state_o !== 16'h7138) begin nerr++; $display("FAIL reject_state got %h exp 7138", state_o); end
    endtask

    task automatic test_fallback();
        do_reset();
        seed_load = 1'b1; seed_in = 16'hFFFF;
        tick();
        seed_load = 1'b0;
        nvec++; if (state2 !== 16'hFFFF) begin nerr++; $display("FAIL fb_seed got %h exp FFFF", state2); end
        req = 1'b1; limit = 4'd1;
        tick();
        req = 1'b0;
        tick();
        nvec++; if (valid2 !== 1'b0 || state2 !== 16'hCBFF) begin nerr++; $display("FAIL fb_reject got vld=%b st=%h exp 0/CBFF", valid2, state2); end
        tick();
        nvec++; if (valid2 !== 1'b1 || rnd2 !== 4'd0 || fb2 !== 1'b1) begin nerr++; $display("FAIL fb_out got vld=%b rnd=%h fb=%b exp 1/0/1", valid2, rnd2, fb2); end
        tick();
        nvec++; if (valid2 !== 1'b0 || fb2 !== 1'b1 || ready2 !== 1'b1) begin nerr++; $display("FAIL fb_hold got vld=%b fb=%b rdy=%b exp 0/1/1", valid2, fb2, ready2); end
    endtask

    task automatic test_misc();
        int extra = 0;
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        nvec++; if (state_o !== 16'hACE1) begin nerr++; $display("FAIL zero_seed got %h exp ACE1", state_o); end

        req = 1'b1; limit = 4'd1;
        tick();                         // accepted
        tick();                         // req still high while busy: ignored
        req = 1'b0;
        tick();
        nvec++; if (valid !== 1'b1 || rnd !== 4'd0) begin nerr++; $display("FAIL busy_valid got vld=%b rnd=%h exp 1/0", valid, rnd); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid) extra++;
        end
        nvec++; if (extra != 0 || ready !== 1'b1) begin nerr++; $display("FAIL busy_req got %0d extra valids rdy=%b exp 0/1", extra, ready); end

        seed_load = 1'b1; seed_in = 16'hFFFF;
        tick();
        seed_load = 1'b0;
        req = 1'b1; limit = 4'd1;
        tick();
        req = 1'b0;
        tick();                         // mid-DRAW (F rejected)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvec++; if (valid !== 1'b0 || ready !== 1'b1 || state_o !== 16'hACE1) begin nerr++; $display("FAIL mid_reset got vld=%b rdy=%b st=%h exp 0/1/ACE1", valid, ready, state_o); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) extra++;
        end
        nvec++; if (extra != 0) begin nerr++; $display("FAIL mid_reset_abandon got %0d valids exp 0", extra); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ranged();
        test_reject();
        test_fallback();
        test_misc();
        test_full_period();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
